// File: rtl/musicbox_seq.sv
// Melody player: walks a note ROM and turns each entry into a square wave on SPEAKER.
// Each entry sets its pitch (semitone + octave), its length in beats and whether it is a rest.
module musicbox_seq #(
    parameter int ADDR_W      = 8,
    parameter int BEAT_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 500000
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              PLAY,
    input  logic              LOOP,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [11:0]       ROM_DATA,
    output logic              SPEAKER,
    output logic              LED,
    output logic              BUSY,
    output logic              DONE
);
    // state   | meaning
    // IDLE    | parked at address 0, waiting for PLAY
    // ADDR    | address stable while the ROM performs its registered read
    // LOAD    | decode entry: end marker handling or note setup
    // NOTE    | tone and duration counters running
    // STOPPED | song finished without looping; wait for PLAY to drop
    typedef enum logic [2:0] {IDLE, ADDR, LOAD, NOTE, STOPPED} state_t;

    localparam logic [31:0]       BEAT      = 32'(BEAT_CYCLES);
    localparam logic [31:0]       GAP       = 32'(GAP_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t      state;
    logic [31:0] dur_cnt;
    logic [19:0] tone_cnt;
    logic [19:0] hp_m1;
    logic        is_rest;
    logic        at_end;

    logic [3:0]  len_m1;
    logic        rest_bit;
    logic [2:0]  oct;
    logic [3:0]  semi;
    logic        end_marker;
    logic        entry_rest;
    logic [19:0] base;
    logic [19:0] hp_new;
    logic [31:0] dur_new;

    always_comb begin
        len_m1     = ROM_DATA[11:8];
        rest_bit   = ROM_DATA[7];
        oct        = ROM_DATA[6:4];
        semi       = ROM_DATA[3:0];
        // at_end: the last address has been played, so the next fetch acts as an end marker
        end_marker = at_end || (rest_bit && (semi == 4'hF));
        entry_rest = rest_bit || (semi >= 4'd12);
        case (semi)
            4'd0:    base = 20'd764458;
            4'd1:    base = 20'd721550;
            4'd2:    base = 20'd681048;
            4'd3:    base = 20'd642824;
            4'd4:    base = 20'd606745;
            4'd5:    base = 20'd572688;
            4'd6:    base = 20'd540541;
            4'd7:    base = 20'd510208;
            4'd8:    base = 20'd481571;
            4'd9:    base = 20'd454545;
            4'd10:   base = 20'd429034;
            4'd11:   base = 20'd404955;
            default: base = 20'd1;
        endcase
        hp_new  = base >> oct;
        dur_new = ({28'd0, len_m1} + 32'd1) * BEAT - 32'd1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state    <= IDLE;
            ROM_ADDR <= '0;
            SPEAKER  <= 1'b0;
            LED      <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            dur_cnt  <= '0;
            tone_cnt <= '0;
            hp_m1    <= '0;
            is_rest  <= 1'b1;
            at_end   <= 1'b0;
        end else begin
            DONE    <= 1'b0;
            SPEAKER <= 1'b0;
            LED     <= 1'b0;
            if ((state inside {ADDR, LOAD, NOTE}) && !PLAY) begin
                state    <= IDLE;
                ROM_ADDR <= '0;
                BUSY     <= 1'b0;
                at_end   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        ROM_ADDR <= '0;
                        at_end   <= 1'b0;
                        if (PLAY) begin
                            state <= ADDR;
                            BUSY  <= 1'b1;
                        end
                    end
                    ADDR: state <= LOAD;
                    LOAD: begin
                        if (end_marker) begin
                            at_end   <= 1'b0;
                            ROM_ADDR <= '0;
                            if (LOOP) begin
                                state <= ADDR;
                            end else begin
                                state <= STOPPED;
                                BUSY  <= 1'b0;
                                DONE  <= 1'b1;
                            end
                        end else begin
                            state    <= NOTE;
                            dur_cnt  <= dur_new;
                            hp_m1    <= hp_new - 20'd1;
                            tone_cnt <= hp_new - 20'd1;
                            is_rest  <= entry_rest;
                            LED      <= !entry_rest && (dur_new >= GAP);
                        end
                    end
                    NOTE: begin
                        if (dur_cnt == '0) begin
                            state <= ADDR;
                            if (ROM_ADDR == LAST_ADDR) at_end <= 1'b1;
                            else ROM_ADDR <= ROM_ADDR + 1'b1;
                        end else begin
                            dur_cnt <= dur_cnt - 32'd1;
                            // outputs are registered, so decide on the sounding state of the next cycle
                            if (!is_rest && (dur_cnt > GAP)) begin
                                LED <= 1'b1;
                                if (tone_cnt == '0) begin
                                    tone_cnt <= hp_m1;
                                    SPEAKER  <= !SPEAKER;
                                end else begin
                                    tone_cnt <= tone_cnt - 20'd1;
                                    SPEAKER  <= SPEAKER;
                                end
                            end else begin
                                tone_cnt <= hp_m1;
                            end
                        end
                    end
                    STOPPED: begin
                        if (!PLAY) state <= IDLE;
                    end
                    default: begin
                        state    <= IDLE;
                        ROM_ADDR <= '0;
                        BUSY     <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_musicbox_seq.sv
// Bench for musicbox_seq: a note-level reference model expands each song into a per-cycle
// expected trace; a monitor compares the DUT against it one segment (note/end/stop) at a time.
module tb_musicbox_seq;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int BEAT   = 1000;
    localparam int GAP    = 100;
    localparam int BIG    = 1000000;

    localparam int K_IDLE  = 0;
    localparam int K_NOTE  = 1;
    localparam int K_END   = 2;
    localparam int K_STOP  = 3;
    localparam int K_ABORT = 4;
    localparam int K_RESET = 5;

    localparam int AB_PLAY  = 0;
    localparam int AB_RESET = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              play;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;
    logic              spk, led, busy, done;
    logic [11:0]       rom [DEPTH];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    musicbox_seq #(.ADDR_W(ADDR_W), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
        .CLOCK_50(clk), .RESET(rst), .PLAY(play), .LOOP(loop_en),
        .ROM_ADDR(rom_addr), .ROM_DATA(rom_data),
        .SPEAKER(spk), .LED(led), .BUSY(busy), .DONE(done)
    );

    typedef struct {
        logic spk;
        logic led;
        logic busy;
        logic done;
        int   addr;
        bit   addr_chk;
        bit   seg_end;
        int   kind;
    } exp_t;

    int base_tab [12] = '{764458, 721550, 681048, 642824, 606745, 572688,
                          540541, 510208, 481571, 454545, 429034, 404955};

    exp_t tr[$];
    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;
    int   seg_no = 0, seg_bad = 0, seg_len = 0;
    exp_t cur, first_exp;
    logic [3:0] first_got;
    int   first_addr, first_at;

    function automatic string kname(int k);
        case (k)
            K_IDLE:  return "idle";
            K_NOTE:  return "note";
            K_END:   return "end_of_song";
            K_STOP:  return "stopped";
            K_ABORT: return "play_drop";
            K_RESET: return "reset";
            default: return "unknown";
        endcase
    endfunction

    function automatic void add(logic s, logic l, logic b, logic d, int a, bit ac, int k);
        exp_t t;
        t.spk = s; t.led = l; t.busy = b; t.done = d;
        t.addr = a; t.addr_chk = ac; t.seg_end = 1'b0; t.kind = k;
        tr.push_back(t);
    endfunction

    function automatic void close_seg();
        exp_t t;
        t = tr.pop_back();
        t.seg_end = 1'b1;
        tr.push_back(t);
    endfunction

    function automatic void flush();
        foreach (tr[i]) expq.push_back(tr[i]);
        tr.delete();
    endfunction

    // Reference: every entry is ADDR + LOAD + (len+1)*BEAT note cycles; the tone is high in
    // the odd half-periods counted from note start, and silent for the last GAP cycles.
    function automatic void build_trace(bit lp, int max_items);
        int         addr, n, hp, k;
        bit         wrapped, is_end, rest_note, snd;
        logic [11:0] e;
        addr = 0;
        wrapped = 1'b0;
        tr.delete();
        add(0, 0, 0, 0, 0, 1, K_IDLE);
        close_seg();
        while (tr.size() < max_items) begin
            e = rom[addr];
            is_end = wrapped || (e[7] && (e[3:0] == 4'hF));
            k = is_end ? K_END : K_NOTE;
            add(0, 0, 1, 0, addr, 1, k);
            add(0, 0, 1, 0, addr, 1, k);
            if (is_end) begin
                close_seg();
                if (lp) begin
                    addr = 0;
                    wrapped = 1'b0;
                end else begin
                    add(0, 0, 0, 1, 0, 0, K_STOP);
                    close_seg();
                    break;
                end
            end else begin
                n = (int'(e[11:8]) + 1) * BEAT;
                rest_note = e[7] || (e[3:0] >= 4'd12);
                hp = rest_note ? 1 : (base_tab[e[3:0]] >> e[6:4]);
                for (int j = 0; j < n; j++) begin
                    snd = !rest_note && (j < n - GAP);
                    add(snd && (((j / hp) % 2) == 1), snd, 1, 0, addr, 1, K_NOTE);
                end
                close_seg();
                if (addr == DEPTH - 1) wrapped = 1'b1;
                else addr++;
            end
        end
    endfunction

    function automatic logic [11:0] rand_note(int max_len);
        logic [11:0] e;
        e[11:8] = 4'($urandom_range(0, max_len));
        e[7]    = ($urandom_range(0, 7) == 0);
        e[6:4]  = 3'($urandom_range(4, 7));
        e[3:0]  = 4'($urandom_range(0, 14));
        return e;
    endfunction

    function automatic void rand_song();
        int n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < DEPTH; i++) rom[i] = 12'($urandom);
        for (int i = 0; i < n; i++) rom[i] = rand_note(2);
        rom[n] = {4'($urandom_range(0, 15)), 1'b1, 3'($urandom_range(0, 7)), 4'hF};
    endfunction

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            cur = expq.pop_front();
            if (spk !== cur.spk || led !== cur.led || busy !== cur.busy || done !== cur.done ||
                (cur.addr_chk && (rom_addr !== 4'(cur.addr)))) begin
                if (seg_bad == 0) begin
                    first_at   = seg_len;
                    first_exp  = cur;
                    first_got  = {spk, led, busy, done};
                    first_addr = int'(rom_addr);
                end
                seg_bad++;
            end
            seg_len++;
            if (cur.seg_end) begin
                checks++;
                if (seg_bad != 0) begin
                    failures++;
                    $display("FAIL %s seg=%0d bad_cycles=%0d/%0d first at cycle %0d: got spk,led,busy,done=%b addr=%0d; want %b addr=%0d",
                             kname(first_exp.kind), seg_no, seg_bad, seg_len, first_at, first_got, first_addr,
                             {first_exp.spk, first_exp.led, first_exp.busy, first_exp.done}, first_exp.addr);
                end
                seg_no++;
                seg_bad = 0;
                seg_len = 0;
            end
        end
    end

    task automatic wait_drain();
        int budget;
        budget = expq.size() + 20;
        for (int k = 0; k < budget && expq.size() > 0; k++) @(posedge clk);
        if (expq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout left=%0d want 0", expq.size());
            expq.delete();
            seg_bad = 0;
            seg_len = 0;
        end
        #1;
    endtask

    // Plays the current ROM. If the model trace reaches max_items, playback is cut there
    // (PLAY drop or RESET); otherwise the song ends and STOPPED is held for 'hold' cycles.
    task automatic run_song(bit lp, int max_items, int abort_kind, int hold);
        bit cut;
        build_trace(lp, max_items);
        cut = (tr.size() >= max_items);
        if (cut) begin
            while (tr.size() > max_items) void'(tr.pop_back());
            close_seg();
        end else if (hold > 0) begin
            for (int k = 0; k < hold; k++) add(0, 0, 0, 0, 0, 0, K_STOP);
            close_seg();
        end
        loop_en = lp;
        play = 1'b1;
        flush();
        if (cut) begin
            repeat (max_items - 1) @(posedge clk);
            #1;
            if (abort_kind == AB_RESET) begin
                rst = 1'b1;
                for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 1, K_RESET);
                close_seg();
                flush();
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                play = 1'b0;
            end else begin
                play = 1'b0;
                for (int k = 0; k < 2; k++) add(0, 0, 0, 0, 0, 1, K_ABORT);
                close_seg();
                flush();
            end
        end
        wait_drain();
        play = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        play = 1'b0;
        loop_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) rom[i] = 12'h000;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) add(0, 0, 0, 0, 0, 1, K_RESET);
        close_seg();
        flush();
        wait_drain();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // one beat of low C then stop; replay after PLAY low->high
        rom[0] = 12'h000;
        rom[1] = 12'h08F;
        run_song(1'b0, BIG, AB_PLAY, 20);
        run_song(1'b0, BIG, AB_PLAY, 5);

        // four-beat rest looping, cut during the third pass
        rom[0] = 12'h380;
        rom[1] = 12'h08F;
        run_song(1'b1, 9500, AB_PLAY, 0);

        // PLAY drop and RESET inside the first note of random songs
        rand_song();
        run_song(1'($urandom_range(0, 1)), $urandom_range(4, 903), AB_PLAY, 0);
        rand_song();
        run_song(1'($urandom_range(0, 1)), $urandom_range(4, 903), AB_RESET, 0);

        // a full 16-entry ROM with no end marker: playback must stop at the last address
        for (int i = 0; i < DEPTH; i++) rom[i] = rand_note(0);
        run_song(1'b0, BIG, AB_PLAY, 5);

        // high B, an out-of-table semitone rest, and A in octave 6
        for (int i = 0; i < DEPTH; i++) rom[i] = 12'h08F;
        rom[0] = 12'h97B;
        rom[1] = 12'h00D;
        rom[2] = 12'h769;
        run_song(1'b0, BIG, AB_PLAY, 5);

        // random songs, random loop mode
        for (int s = 0; s < 2; s++) begin
            rand_song();
            if ($urandom_range(0, 1) == 1) run_song(1'b1, $urandom_range(2000, 6000), AB_PLAY, 0);
            else run_song(1'b0, BIG, AB_PLAY, 10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
